xmii_to_axis: RTL and testbench
===============================

Name: xmii_to_axis

Overview:
- Parametrised successor to mii_to_axis.
- Receives a PHY-side nibble/dibit/byte stream (RMII-style 2-bit, MII 4-bit or GMII 8-bit data path) and validates preamble/SFD.
- Optionally checks and strips the Ethernet FCS, then emits the payload as an 8-bit AXI4-Stream with tlast and a per-frame error flag on tuser.
- Sits between the PHY pins and the MAC receive path; the output has no backpressure.

Parameters:
PHY_WIDTH, 4, PHY data width; legal values 2, 4, 8.
CHECK_FCS, 1, 1 = check CRC-32 and strip the 4 FCS bytes; 0 = pass all post-SFD bytes through, no CRC check.
MIN_PREAMBLE_BYTES, 1, minimum number of 0x55 bytes that must precede 0xD5 for the SFD to be accepted.

Ports:
clock  in  1  single clock; all inputs are sampled and all outputs are driven on its rising edge.
aresetn  in  1  asynchronous, active-low reset.
mii_d  in  PHY_WIDTH  receive data, least significant group first within each byte.
mii_dv  in  1  receive data valid.
mii_er  in  1  receive error.
maxis_tdata  out  8  payload byte.
maxis_tvalid  out  1  beat valid; single-cycle strobe, no tready.
maxis_tlast  out  1  last payload byte of the frame.
maxis_tuser  out  1  frame-error flag; meaningful only when tlast=1.
stat_frame_ok  out  1  one-cycle pulse at end of a good frame.
stat_frame_err  out  1  one-cycle pulse at end of a bad frame that passed SFD.

Behaviour:
- Reset is asynchronous: all outputs go to 0 immediately and state goes to IDLE. CRC register, byte assembler and delay line are cleared.
- Byte assembly: each group received while mii_dv=1 is shifted into byte bits [PHY_WIDTH*k +: PHY_WIDTH], k = 0..8/PHY_WIDTH-1. A byte completes on its last group.
- IDLE: if mii_dv=1, go to PREAMBLE and consume the current group as the first preamble group.
- PREAMBLE:
  - Completed byte 0x55: count++ (saturating).
  - Completed byte 0xD5 with count >= MIN_PREAMBLE_BYTES: go to DATA.
  - Any other completed byte: go to DROP.
  - mii_dv=0: go to IDLE, no output, no stat pulse.
- DATA:
  - Each completed byte updates the CRC and enters a delay line of depth D+1, where D = 4 if CHECK_FCS else 0.
  - When the line is full, the oldest byte is emitted with tvalid=1, tlast=0. It is registered and appears one cycle after the sample that completed the newer byte.
  - mii_er=1 on any DATA cycle sets a sticky error.
  - mii_dv=0 ends the frame. On the next cycle the newest byte left in the payload slot, if any, is emitted with tlast=1 and tuser=error. Exactly one of stat_frame_ok or stat_frame_err pulses on that same cycle. State returns to IDLE.
- End-of-frame error = sticky mii_er, OR a partial byte in the assembler (dribble), OR (CHECK_FCS and CRC residue mismatch), OR fewer than D+1 bytes received.
  - If no payload byte exists (short frame), no AXIS beat is emitted; only stat_frame_err pulses.
- CRC: reflected polynomial 0xEDB88320, register initialised to 0xFFFFFFFF at SFD, updated over every post-SFD byte including the FCS, LSB-first. Frame is good iff register == 0xDEBB20E3 after the last byte.
- DROP: ignore input until mii_dv=0, then go to IDLE. No output, no stat pulse.
- If mii_dv=1 on the first clock after reset release, go to DROP; a frame is never picked up mid-stream.
- mii_er during PREAMBLE: go to DROP.
- Back-to-back frames: mii_dv high again on the cycle right after the frame-end cycle is accepted as a new frame. The end-of-frame beat and the new preamble are processed concurrently.
- Throughput: at most one beat per 8/PHY_WIDTH cycles.
  - For PHY_WIDTH=8, a beat is emitted every cycle during DATA.

Test Plan:
1. PHY_WIDTH=4, CHECK_FCS=0: 7×0x55, 0xD5, then payload 01 02 03 → three beats 01, 02, 03; tlast only on 03, tuser=0; one stat_frame_ok pulse.
2. CHECK_FCS=1: 60-byte random payload + correct FCS → exactly 60 beats, tuser=0, stat_frame_ok. Same frame with payload bit 0 of byte 10 flipped → 60 beats, tuser=1 on the last beat, stat_frame_err.
3. mii_er held 1 for one cycle in mid-payload of a 5-byte CHECK_FCS=0 frame → 5 beats, tuser=1 on the last beat, stat_frame_err.
4. mii_dv drops after an odd nibble count (PHY_WIDTH=4) → tuser=1 on the last beat. Bad SFD 0x5D → no beats and no stat pulse until mii_dv=0; the following good frame is received intact.
5. CHECK_FCS=1, frame of only 3 bytes after SFD → no beats, one stat_frame_err.
6. PHY_WIDTH=2 and 8: 200 random frames of 1–24 bytes from a matching serializer, with random 0–2 cycle gaps → byte-exact match with correct tlast.
7. aresetn pulsed low mid-payload → all outputs 0 asynchronously; the rest of that frame is dropped; the next frame is received intact.

Source files
------------

// File: rtl/xmii_to_axis_if.sv
// Byte-wide AXI4-Stream receive channel without backpressure, as driven by the
// PHY-side frame receiver.
interface xmii_to_axis_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tvalid, tlast, tuser);
  modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/xmii_to_axis.sv
// PHY receive path (2/4/8-bit groups) to 8-bit AXI4-Stream: preamble/SFD detection,
// optional CRC-32 check and FCS strip, per-frame error flag and status pulses.
module xmii_to_axis #(
  parameter int unsigned PHY_WIDTH          = 4,
  parameter bit          CHECK_FCS          = 1'b1,
  parameter int unsigned MIN_PREAMBLE_BYTES = 1
) (
  input  logic                 clock,
  input  logic                 aresetn,
  input  logic [PHY_WIDTH-1:0] mii_d,
  input  logic                 mii_dv,
  input  logic                 mii_er,
  xmii_to_axis_if.master       maxis,
  output logic                 stat_frame_ok,
  output logic                 stat_frame_err
);

  localparam int unsigned Groups = 8 / PHY_WIDTH;
  // Payload slot plus the four FCS bytes held back so they can be stripped.
  localparam int unsigned Depth  = CHECK_FCS ? 5 : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPre  = 2'd1;
  localparam logic [1:0] StData = 2'd2;
  localparam logic [1:0] StDrop = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  first_q;
  logic [1:0]            grp_q, grp_d;
  logic [7:0]            asm_q, asm_d;
  logic [7:0]            pre_cnt_q, pre_cnt_d;
  logic [2:0]            nbytes_q, nbytes_d;
  logic                  err_q, err_d;
  logic [31:0]           crc_q, crc_d;
  logic [Depth-1:0][7:0] dl_q, dl_d;
  logic [7:0]            tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  tuser_q, tuser_d;
  logic                  ok_q, ok_d;
  logic                  bad_q, bad_d;

  logic [2:0]            lsb;
  logic [7:0]            cur_byte;
  logic [7:0]            pre_cnt_base;
  logic                  byte_done;
  logic                  frame_err;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // The byte as it stands including the group on the bus this cycle.
  assign lsb          = 3'(grp_q * PHY_WIDTH);
  assign cur_byte     = ((grp_q == 2'd0) ? 8'h00 : asm_q) | (8'(mii_d) << lsb);
  assign byte_done    = mii_dv && (grp_q == 2'(Groups - 1));
  assign pre_cnt_base = (state_q == StIdle) ? 8'd0 : pre_cnt_q;
  assign frame_err    = err_q | mii_er | (grp_q != 2'd0) | (nbytes_q != 3'(Depth)) |
                        (CHECK_FCS && (crc_q != 32'hDEBB20E3));

  always_comb begin
    state_d   = state_q;
    grp_d     = 2'd0;
    asm_d     = 8'h00;
    pre_cnt_d = pre_cnt_q;
    nbytes_d  = nbytes_q;
    err_d     = err_q;
    crc_d     = crc_q;
    dl_d      = dl_q;
    tdata_d   = 8'h00;
    tvalid_d  = 1'b0;
    tlast_d   = 1'b0;
    tuser_d   = 1'b0;
    ok_d      = 1'b0;
    bad_d     = 1'b0;

    if (mii_dv) begin
      asm_d = cur_byte;
      grp_d = byte_done ? 2'd0 : grp_q + 2'd1;
    end

    unique case (state_q)
      StIdle, StPre: begin
        if (!mii_dv) begin
          state_d = StIdle;
        end else if (first_q || mii_er) begin
          // Never lock onto a stream already in flight when reset releases.
          state_d = StDrop;
        end else begin
          state_d   = StPre;
          pre_cnt_d = pre_cnt_base;
          if (byte_done) begin
            if (cur_byte == 8'h55) begin
              if (pre_cnt_base != 8'hFF) pre_cnt_d = pre_cnt_base + 8'd1;
            end else if (cur_byte == 8'hD5 && 32'(pre_cnt_base) >= MIN_PREAMBLE_BYTES) begin
              state_d  = StData;
              crc_d    = 32'hFFFFFFFF;
              nbytes_d = 3'd0;
              err_d    = 1'b0;
            end else begin
              state_d = StDrop;
            end
          end
        end
      end
      StData: begin
        if (mii_dv) begin
          if (mii_er) err_d = 1'b1;
          if (byte_done) begin
            crc_d = crc_step(crc_q, cur_byte);
            for (int i = Depth - 1; i > 0; i--) dl_d[i] = dl_q[i-1];
            dl_d[0] = cur_byte;
            if (nbytes_q == 3'(Depth)) begin
              tvalid_d = 1'b1;
              tdata_d  = dl_q[Depth-1];
            end else begin
              nbytes_d = nbytes_q + 3'd1;
            end
          end
        end else begin
          if (nbytes_q == 3'(Depth)) begin
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tuser_d  = frame_err;
            tdata_d  = dl_q[Depth-1];
          end
          ok_d    = ~frame_err;
          bad_d   = frame_err;
          state_d = StIdle;
        end
      end
      StDrop: begin
        if (!mii_dv) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      first_q   <= 1'b1;
      grp_q     <= 2'd0;
      asm_q     <= 8'h00;
      pre_cnt_q <= 8'd0;
      nbytes_q  <= 3'd0;
      err_q     <= 1'b0;
      crc_q     <= 32'h0;
      dl_q      <= '0;
      tdata_q   <= 8'h00;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= 1'b0;
      ok_q      <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      first_q   <= 1'b0;
      grp_q     <= grp_d;
      asm_q     <= asm_d;
      pre_cnt_q <= pre_cnt_d;
      nbytes_q  <= nbytes_d;
      err_q     <= err_d;
      crc_q     <= crc_d;
      dl_q      <= dl_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tuser_q   <= tuser_d;
      ok_q      <= ok_d;
      bad_q     <= bad_d;
    end
  end

  assign maxis.tdata    = tdata_q;
  assign maxis.tvalid   = tvalid_q;
  assign maxis.tlast    = tlast_q;
  assign maxis.tuser    = tuser_q;
  assign stat_frame_ok  = ok_q;
  assign stat_frame_err = bad_q;

endmodule

// File: tb/tb_xmii_to_axis.sv
// Directed bench for xmii_to_axis: four instances cover 4-bit (with and without FCS),
// 2-bit and 8-bit PHY paths; beats are logged at the falling edge and compared per test.
module tb_xmii_to_axis;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       aresetn;
  logic [7:0] md [4];
  logic       dv [4];
  logic       er [4];
  logic       ok_w [4];
  logic       bad_w [4];
  logic       vld_w [4];
  logic [9:0] beat_w [4];

  xmii_to_axis_if ax0 ();
  xmii_to_axis_if ax1 ();
  xmii_to_axis_if ax2 ();
  xmii_to_axis_if ax3 ();

  xmii_to_axis #(.PHY_WIDTH(4), .CHECK_FCS(1'b0), .MIN_PREAMBLE_BYTES(1)) u_dut0 (
    .clock(clock), .aresetn(aresetn), .mii_d(md[0][3:0]), .mii_dv(dv[0]), .mii_er(er[0]),
    .maxis(ax0), .stat_frame_ok(ok_w[0]), .stat_frame_err(bad_w[0]));
  xmii_to_axis #(.PHY_WIDTH(4), .CHECK_FCS(1'b1), .MIN_PREAMBLE_BYTES(1)) u_dut1 (
    .clock(clock), .aresetn(aresetn), .mii_d(md[1][3:0]), .mii_dv(dv[1]), .mii_er(er[1]),
    .maxis(ax1), .stat_frame_ok(ok_w[1]), .stat_frame_err(bad_w[1]));
  xmii_to_axis #(.PHY_WIDTH(2), .CHECK_FCS(1'b1), .MIN_PREAMBLE_BYTES(1)) u_dut2 (
    .clock(clock), .aresetn(aresetn), .mii_d(md[2][1:0]), .mii_dv(dv[2]), .mii_er(er[2]),
    .maxis(ax2), .stat_frame_ok(ok_w[2]), .stat_frame_err(bad_w[2]));
  xmii_to_axis #(.PHY_WIDTH(8), .CHECK_FCS(1'b0), .MIN_PREAMBLE_BYTES(1)) u_dut3 (
    .clock(clock), .aresetn(aresetn), .mii_d(md[3]), .mii_dv(dv[3]), .mii_er(er[3]),
    .maxis(ax3), .stat_frame_ok(ok_w[3]), .stat_frame_err(bad_w[3]));

  assign vld_w[0]  = ax0.tvalid;
  assign vld_w[1]  = ax1.tvalid;
  assign vld_w[2]  = ax2.tvalid;
  assign vld_w[3]  = ax3.tvalid;
  assign beat_w[0] = {ax0.tuser, ax0.tlast, ax0.tdata};
  assign beat_w[1] = {ax1.tuser, ax1.tlast, ax1.tdata};
  assign beat_w[2] = {ax2.tuser, ax2.tlast, ax2.tdata};
  assign beat_w[3] = {ax3.tuser, ax3.tlast, ax3.tdata};

  // Beat log per instance: {tuser, tlast, tdata}; counters only ever grow.
  logic [9:0] beats [4][0:8191];
  int         nbeat [4];
  int         nok [4];
  int         nerr [4];
  int         nboth;

  initial begin
    for (int i = 0; i < 4; i++) begin
      nbeat[i] = 0;
      nok[i]   = 0;
      nerr[i]  = 0;
    end
    nboth = 0;
  end

  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (vld_w[i]) begin
        if (nbeat[i] < 8192) beats[i][nbeat[i]] <= beat_w[i];
        nbeat[i] <= nbeat[i] + 1;
      end
      if (ok_w[i])  nok[i]  <= nok[i] + 1;
      if (bad_w[i]) nerr[i] <= nerr[i] + 1;
      if (ok_w[i] && bad_w[i]) nboth <= nboth + 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp_v);
  endtask

  logic [7:0] pay [0:255];
  logic [7:0] fb [0:511];
  int         flen;
  logic [9:0] exp_b [0:8191];
  int         nexp;
  int         base_b, base_ok, base_err;

  function automatic int pw_of(input int id);
    case (id)
      2:       return 2;
      3:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, pay[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build(input int npre, input int npay, input bit fcs);
    logic [31:0] c;
    flen = 0;
    for (int i = 0; i < npre; i++) begin
      fb[flen] = 8'h55;
      flen++;
    end
    fb[flen] = 8'hD5;
    flen++;
    for (int i = 0; i < npay; i++) begin
      fb[flen] = pay[i];
      flen++;
    end
    if (fcs) begin
      c = ~crc_of(npay);
      for (int i = 0; i < 4; i++) begin
        fb[flen] = c[8*i +: 8];
        flen++;
      end
    end
  endtask

  task automatic push_exp(input int npay, input bit tuser);
    for (int j = 0; j < npay; j++) begin
      exp_b[nexp] = {(j == npay - 1) ? tuser : 1'b0, j == npay - 1, pay[j]};
      nexp++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic snap(input int id);
    base_b   = nbeat[id];
    base_ok  = nok[id];
    base_err = nerr[id];
    nexp     = 0;
  endtask

  // Serialises fb[0..flen-1] LSB group first; optional dribble groups, a one-cycle
  // mii_er at a byte, and an asynchronous reset pulse at a byte.
  task automatic send_frame(input int id, input int extra, input int er_at, input int rst_at);
    int pw;
    pw = pw_of(id);
    for (int b = 0; b < flen; b++) begin
      for (int k = 0; k < 8 / pw; k++) begin
        @(negedge clock);
        md[id] = fb[b] >> (pw * k);
        dv[id] = 1'b1;
        er[id] = (b == er_at) && (k == 0);
        if (b == rst_at && k == 0) begin
          check_eq("t7_pre_tvalid", vld_w[id], 1);
          #1 aresetn = 1'b0;
          #1 check_eq("t7_rst_outputs", {ok_w[id], bad_w[id], vld_w[id], beat_w[id]}, 0);
          #2 aresetn = 1'b1;
        end
      end
    end
    for (int k = 0; k < extra; k++) begin
      @(negedge clock);
      md[id] = 8'h00;
      dv[id] = 1'b1;
      er[id] = 1'b0;
    end
    @(negedge clock);
    md[id] = 8'h00;
    dv[id] = 1'b0;
    er[id] = 1'b0;
  endtask

  task automatic compare_beats(input string tag, input int id);
    int got_n, mism;
    logic [9:0] mask;
    got_n = nbeat[id] - base_b;
    mism  = 0;
    check_eq({tag, "_nbeat"}, got_n, nexp);
    for (int j = 0; j < nexp && j < got_n; j++) begin
      mask = exp_b[j][8] ? 10'h3FF : 10'h1FF;
      if (((beats[id][base_b + j] ^ exp_b[j]) & mask) != 10'h0) mism++;
    end
    check_eq({tag, "_beats_wrong"}, mism, 0);
  endtask

  task automatic check_stats(input string tag, input int id, input int eok, input int eerr);
    check_eq({tag, "_ok"}, nok[id] - base_ok, eok);
    check_eq({tag, "_err"}, nerr[id] - base_err, eerr);
  endtask

  initial begin
    aresetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      md[i] = 8'h00;
      dv[i] = 1'b0;
      er[i] = 1'b0;
    end
    idle(3);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rst_outputs_%0d", i),
               {ok_w[i], bad_w[i], vld_w[i], beat_w[i]}, 0);
    end
    aresetn = 1'b1;
    idle(3);

    // 1: 4-bit, no FCS, payload 01 02 03.
    snap(0);
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    build(7, 3, 1'b0);
    send_frame(0, 0, -1, -1);
    idle(4);
    check_eq("t1_nbeat", nbeat[0] - base_b, 3);
    check_eq("t1_beat0", beats[0][base_b] & 10'h1FF, 10'h001);
    check_eq("t1_beat1", beats[0][base_b + 1] & 10'h1FF, 10'h002);
    check_eq("t1_beat2", beats[0][base_b + 2], 10'h103);
    check_stats("t1", 0, 1, 0);

    // 3: one-cycle mii_er inside a 5-byte payload.
    snap(0);
    for (int i = 0; i < 5; i++) pay[i] = 8'h10 + 8'(i);
    build(7, 5, 1'b0);
    send_frame(0, 0, 10, -1);
    idle(4);
    check_eq("t3_last", beats[0][base_b + 4], 10'h314);
    push_exp(5, 1'b1);
    compare_beats("t3", 0);
    check_stats("t3", 0, 0, 1);

    // 4a: odd nibble count (dribble).
    snap(0);
    pay[0] = 8'hAA; pay[1] = 8'hBB;
    build(7, 2, 1'b0);
    send_frame(0, 1, -1, -1);
    idle(4);
    push_exp(2, 1'b1);
    compare_beats("t4_dribble", 0);
    check_stats("t4_dribble", 0, 0, 1);

    // 4b: bad SFD 0x5D, then a good frame.
    snap(0);
    pay[0] = 8'h21; pay[1] = 8'h22;
    build(7, 2, 1'b0);
    fb[7] = 8'h5D;
    send_frame(0, 0, -1, -1);
    idle(4);
    check_eq("t4_badsfd_nbeat", nbeat[0] - base_b, 0);
    check_stats("t4_badsfd", 0, 0, 0);
    snap(0);
    build(7, 2, 1'b0);
    send_frame(0, 0, -1, -1);
    idle(4);
    push_exp(2, 1'b0);
    compare_beats("t4_after", 0);
    check_stats("t4_after", 0, 1, 0);

    // 2: 60-byte payload with correct FCS, then with a payload bit flipped.
    snap(1);
    for (int i = 0; i < 60; i++) pay[i] = 8'($urandom);
    build(7, 60, 1'b1);
    send_frame(1, 0, -1, -1);
    idle(6);
    push_exp(60, 1'b0);
    compare_beats("t2_good", 1);
    check_stats("t2_good", 1, 1, 0);
    snap(1);
    fb[8 + 10] = fb[8 + 10] ^ 8'h01;
    pay[10]    = pay[10] ^ 8'h01;
    send_frame(1, 0, -1, -1);
    idle(6);
    push_exp(60, 1'b1);
    compare_beats("t2_bad", 1);
    check_stats("t2_bad", 1, 0, 1);

    // 5: only 3 bytes after SFD with FCS checking on.
    snap(1);
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    build(7, 3, 1'b0);
    send_frame(1, 0, -1, -1);
    idle(6);
    check_eq("t5_nbeat", nbeat[1] - base_b, 0);
    check_stats("t5", 1, 0, 1);

    // 6: 200 random frames each on the 2-bit (FCS) and 8-bit (no FCS) paths.
    for (int id = 2; id < 4; id++) begin
      snap(id);
      for (int f = 0; f < 200; f++) begin
        int npay;
        npay = int'($urandom_range(1, 24));
        for (int i = 0; i < npay; i++) pay[i] = 8'($urandom);
        build(int'($urandom_range(1, 7)), npay, id == 2);
        push_exp(npay, 1'b0);
        send_frame(id, 0, -1, -1);
        idle(int'($urandom_range(0, 2)));
      end
      idle(10);
      compare_beats($sformatf("t6_pw%0d", pw_of(id)), id);
      check_stats($sformatf("t6_pw%0d", pw_of(id)), id, 200, 0);
    end

    // 7: reset mid-payload, rest of that frame dropped, next frame intact.
    snap(0);
    for (int i = 0; i < 6; i++) pay[i] = 8'h41 + 8'(i);
    build(7, 6, 1'b0);
    send_frame(0, 0, -1, 11);
    idle(4);
    exp_b[0] = 10'h041;
    exp_b[1] = 10'h042;
    nexp = 2;
    pay[0] = 8'h31; pay[1] = 8'h32; pay[2] = 8'h33;
    build(7, 3, 1'b0);
    send_frame(0, 0, -1, -1);
    idle(4);
    push_exp(3, 1'b0);
    compare_beats("t7", 0);
    check_stats("t7", 0, 1, 0);

    check_eq("stat_ok_err_exclusive", nboth, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
